// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the tinyGPU register file write port.
//
// Merges two result producers onto the single register-file write port:
//   - the single-cycle ALU, which normally has priority;
//   - the multi-cycle LSU, whose results wait in a small in-order queue.
// A starvation counter stalls the ALU once the queue head has waited
// STARVE_MAX cycles, so queued LSU results always drain.
//
// Parameters:
//   LQ_DEPTH   - LSU result queue entries (2 or 4)
//   STARVE_MAX - cycles the queue head may wait before the ALU is stalled (1..15)
//
// Ports:
//   CLK, Reset           - clock, synchronous active-high reset
//   alu_valid/ready      - ALU result handshake; alu_rd/alu_data carry the result
//   lsu_valid/ready      - LSU result handshake; lsu_rd/lsu_data carry the result
//   nD, D, RegWE         - registered register-file write index, data, enable
//   lq_count             - current queue occupancy (0..LQ_DEPTH)
module wb_arbiter #(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_rd,
  input  logic [15:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [3:0]  lsu_rd,
  input  logic [15:0] lsu_data,
  output logic [3:0]  nD,
  output logic [15:0] D,
  output logic        RegWE,
  output logic [2:0]  lq_count
);

  localparam int               PTR_W    = (LQ_DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]       DEPTH_C  = 3'(LQ_DEPTH);
  localparam logic [3:0]       STARVE_C = 4'(STARVE_MAX);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Saturating increment of the starvation counter.
  function automatic logic [3:0] starve_inc(input logic [3:0] v);
    if (v == STARVE_C) begin
      return v;
    end
    return v + 4'd1;
  endfunction

  // Control state
  logic [2:0]       count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [3:0]       starve_q, starve_d;
  logic             regwe_q, regwe_d;
  logic [3:0]       nd_q, nd_d;
  logic [15:0]      d_q, d_d;

  // Queue storage (data only, never reset: count decides what is live)
  logic [3:0]  lq_rd_q   [LQ_DEPTH];
  logic [3:0]  lq_rd_d   [LQ_DEPTH];
  logic [15:0] lq_data_q [LQ_DEPTH];
  logic [15:0] lq_data_d [LQ_DEPTH];

  logic alu_issue;
  logic push;
  logic pop;

  always_comb begin
    alu_ready = !Reset && (starve_q != STARVE_C);
    lsu_ready = !Reset && (count_q < DEPTH_C);

    // r0 beats are accepted but never reach the write port or the queue.
    alu_issue = alu_valid && alu_ready && (alu_rd != 4'd0);
    push      = lsu_valid && lsu_ready && (lsu_rd != 4'd0);
    pop       = !alu_issue && (count_q != 3'd0);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    head_d = pop  ? head_q + PTR_ONE : head_q;
    tail_d = push ? tail_q + PTR_ONE : tail_q;

    lq_rd_d   = lq_rd_q;
    lq_data_d = lq_data_q;
    if (push) begin
      lq_rd_d[tail_q]   = lsu_rd;
      lq_data_d[tail_q] = lsu_data;
    end

    // The head only ages while it is actually waiting behind the ALU.
    if ((count_q == 3'd0) || pop) begin
      starve_d = 4'd0;
    end else begin
      starve_d = starve_inc(starve_q);
    end

    regwe_d = alu_issue || pop;
    nd_d    = nd_q;
    d_d     = d_q;
    if (alu_issue) begin
      nd_d = alu_rd;
      d_d  = alu_data;
    end else if (pop) begin
      nd_d = lq_rd_q[head_q];
      d_d  = lq_data_q[head_q];
    end
  end

  // Stage boundary: arbitration -> register-file write port
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_q  <= 3'd0;
      head_q   <= '0;
      tail_q   <= '0;
      starve_q <= 4'd0;
      regwe_q  <= 1'b0;
      nd_q     <= 4'd0;
      d_q      <= 16'd0;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      starve_q <= starve_d;
      regwe_q  <= regwe_d;
      nd_q     <= nd_d;
      d_q      <= d_d;
    end
  end

  always_ff @(posedge CLK) begin
    lq_rd_q   <= lq_rd_d;
    lq_data_q <= lq_data_d;
  end

  assign nD       = nd_q;
  assign D        = d_q;
  assign RegWE    = regwe_q;
  assign lq_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (LQ_DEPTH=2, STARVE_MAX=3).
// A table of per-cycle input/expected-output records, followed by
// hand-written sequences for starvation, mid-operation reset and wrap.
module tb_wb_arbiter;

  logic        CLK;
  logic        Reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [3:0]  lsu_rd;
  logic [15:0] lsu_data;
  logic [3:0]  nD;
  logic [15:0] D;
  logic        RegWE;
  logic [2:0]  lq_count;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.LQ_DEPTH(2), .STARVE_MAX(3)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .nD        (nD),
    .D         (D),
    .RegWE     (RegWE),
    .lq_count  (lq_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        av;
    logic [3:0]  ard;
    logic [15:0] ad;
    logic        lv;
    logic [3:0]  lrd;
    logic [15:0] ld;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic [3:0]  e_nd;
    logic [15:0] e_d;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic av, input logic [3:0] ard,
                       input logic [15:0] ad, input logic lv, input logic [3:0] lrd,
                       input logic [15:0] ld);
    Reset     = rst;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = ld;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // rst, av, ard, ad, lv, lrd, ld | ar, lr, we, nd, d, cnt
    tbl[0]  = '{1'b1, 1'b1, 4'd5, 16'h1111, 1'b1, 4'd3, 16'h2222, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 3'd0};
    tbl[1]  = '{1'b1, 1'b1, 4'd5, 16'h1111, 1'b1, 4'd3, 16'h2222, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 3'd0};
    tbl[2]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 3'd0};
    tbl[3]  = '{1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 3'd0};
    tbl[4]  = '{1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd5, 16'h1234, 3'd0};
    tbl[5]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd5, 16'h1234, 3'd0};
    tbl[6]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 16'hAAAA, 1'b1, 1'b1, 1'b0, 4'd5, 16'h1234, 3'd0};
    tbl[7]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 16'hBBBB, 1'b1, 1'b1, 1'b0, 4'd5, 16'h1234, 3'd1};
    tbl[8]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd3, 16'hAAAA, 3'd1};
    tbl[9]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd4, 16'hBBBB, 3'd0};
    tbl[10] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd4, 16'hBBBB, 3'd0};
    tbl[11] = '{1'b0, 1'b1, 4'd1, 16'h0011, 1'b1, 4'd5, 16'h5555, 1'b1, 1'b1, 1'b0, 4'd4, 16'hBBBB, 3'd0};
    tbl[12] = '{1'b0, 1'b1, 4'd1, 16'h0012, 1'b1, 4'd6, 16'h6666, 1'b1, 1'b1, 1'b1, 4'd1, 16'h0011, 3'd1};
    tbl[13] = '{1'b0, 1'b1, 4'd1, 16'h0013, 1'b1, 4'd7, 16'h7777, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0012, 3'd2};
    tbl[14] = '{1'b0, 1'b1, 4'd1, 16'h0014, 1'b1, 4'd7, 16'h7777, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0013, 3'd2};
    tbl[15] = '{1'b0, 1'b1, 4'd1, 16'h0015, 1'b1, 4'd7, 16'h7777, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0014, 3'd2};
    tbl[16] = '{1'b0, 1'b1, 4'd1, 16'h0015, 1'b1, 4'd7, 16'h7777, 1'b1, 1'b1, 1'b1, 4'd5, 16'h5555, 3'd1};
    tbl[17] = '{1'b0, 1'b1, 4'd1, 16'h0016, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0015, 3'd2};
    tbl[18] = '{1'b0, 1'b1, 4'd1, 16'h0017, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0016, 3'd2};
    tbl[19] = '{1'b0, 1'b1, 4'd1, 16'h0018, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0017, 3'd2};
    tbl[20] = '{1'b0, 1'b1, 4'd1, 16'h0018, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd6, 16'h6666, 3'd1};
    tbl[21] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd1, 16'h0018, 3'd1};
    tbl[22] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd7, 16'h7777, 3'd0};
    tbl[23] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd7, 16'h7777, 3'd0};

    drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    next_cycle();

    // Table: reset, ALU path, r0, LSU FIFO order, backpressure, throttling.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      @(negedge CLK);
      check($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      check($sformatf("v%0d_lsu_ready", i), 32'(lsu_ready), 32'(tbl[i].e_lr));
      check($sformatf("v%0d_RegWE", i),     32'(RegWE),     32'(tbl[i].e_we));
      check($sformatf("v%0d_nD", i),        32'(nD),        32'(tbl[i].e_nd));
      check($sformatf("v%0d_D", i),         32'(D),         32'(tbl[i].e_d));
      check($sformatf("v%0d_lq_count", i),  32'(lq_count),  32'(tbl[i].e_cnt));
      next_cycle();
    end

    // Starvation: ALU continuously valid to r1, one LSU entry pushed at k=0.
    drive(1'b0, 1'b1, 4'd1, 16'h00A0, 1'b0, 4'd0, 16'h0000);
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 4'd1, 16'h00A0, (k == 0), 4'd7, 16'h0707);
      @(negedge CLK);
      if (k == 0) begin
        check("starve_push_lsu_ready", 32'(lsu_ready), 32'd1);
      end else begin
        check($sformatf("starve_k%0d_alu_ready", k), 32'(alu_ready), (k == 4) ? 32'd0 : 32'd1);
        check($sformatf("starve_k%0d_RegWE", k), 32'(RegWE), 32'd1);
        check($sformatf("starve_k%0d_nD", k), 32'(nD), (k == 5) ? 32'd7 : 32'd1);
        check($sformatf("starve_k%0d_D", k), 32'(D), (k == 5) ? 32'h0707 : 32'h00A0);
        check($sformatf("starve_k%0d_lq_count", k), 32'(lq_count), (k <= 4) ? 32'd1 : 32'd0);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    next_cycle();
    next_cycle();

    // Mid-operation reset: fill the queue behind a busy ALU, then pulse Reset.
    drive(1'b0, 1'b1, 4'd2, 16'h0202, 1'b1, 4'd9, 16'h0909);
    @(negedge CLK);
    check("fill_a_lsu_ready", 32'(lsu_ready), 32'd1);
    next_cycle();
    drive(1'b0, 1'b1, 4'd2, 16'h0203, 1'b1, 4'd10, 16'h0A0A);
    @(negedge CLK);
    check("fill_b_lq_count", 32'(lq_count), 32'd1);
    check("fill_b_lsu_ready", 32'(lsu_ready), 32'd1);
    next_cycle();
    drive(1'b1, 1'b1, 4'd2, 16'h0204, 1'b1, 4'd11, 16'h0B0B);
    @(negedge CLK);
    check("rst_pulse_lq_count", 32'(lq_count), 32'd2);
    check("rst_pulse_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_pulse_lsu_ready", 32'(lsu_ready), 32'd0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
      @(negedge CLK);
      check($sformatf("post_rst%0d_lq_count", k), 32'(lq_count), 32'd0);
      check($sformatf("post_rst%0d_RegWE", k), 32'(RegWE), 32'd0);
      if (k == 0) begin
        check("post_rst_nD", 32'(nD), 32'd0);
        check("post_rst_D", 32'(D), 32'd0);
      end
      next_cycle();
    end

    // Wrap: five back-to-back LSU pushes, each written two cycles later.
    for (int j = 0; j < 8; j++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h0000, (j < 5), 4'(8 + j), 16'hC000 + 16'(j));
      @(negedge CLK);
      check($sformatf("wrap_j%0d_lsu_ready", j), 32'(lsu_ready), 32'd1);
      check($sformatf("wrap_j%0d_lq_count", j), 32'(lq_count),
            ((j >= 1) && (j <= 5)) ? 32'd1 : 32'd0);
      if ((j >= 2) && (j <= 6)) begin
        check($sformatf("wrap_j%0d_RegWE", j), 32'(RegWE), 32'd1);
        check($sformatf("wrap_j%0d_nD", j), 32'(nD), 32'(8 + j - 2));
        check($sformatf("wrap_j%0d_D", j), 32'(D), 32'h0000C000 + 32'(j - 2));
      end else begin
        check($sformatf("wrap_j%0d_RegWE", j), 32'(RegWE), 32'd0);
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the tinyGPU datapath. It sits directly upstream of the 16×16-bit register file and drives that file's single write port (nD, D, RegWE). It merges results from two producers:
- the single-cycle ALU, which has priority;
- the multi-cycle load/store unit (LSU), whose results are buffered in a small in-order queue.

A starvation counter throttles the ALU so that queued LSU results always drain.

## Interface
Parameters:
- LQ_DEPTH, 2 — LSU result queue entries; legal values 2 or 4.
- STARVE_MAX, 3 — consecutive cycles the queue head may wait before the ALU is stalled; range 1–15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result valid this cycle.
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
- alu_rd  in  4  ALU destination register.
- alu_data  in  16  ALU result.
- lsu_valid  in  1  LSU result valid.
- lsu_ready  out  1  LSU result accepted when lsu_valid && lsu_ready.
- lsu_rd  in  4  LSU destination register.
- lsu_data  in  16  LSU load data.
- nD  out  4  register-file write index (registered).
- D  out  16  register-file write data (registered).
- RegWE  out  1  register-file write enable (registered).
- lq_count  out  3  current queue occupancy, 0..LQ_DEPTH.

## Operation
- **Queue:** circular buffer of LQ_DEPTH entries {rd, data}, with head/tail pointers and a count register.
  - lsu_ready = !Reset && (count < LQ_DEPTH). No push when full, even if a pop occurs in the same cycle.
- **r0 rule:** register 0 is never written.
  - An ALU beat with alu_rd==0 is accepted (when alu_ready) and discarded. It does not request the port.
  - An LSU beat with lsu_rd==0 is accepted and not enqueued.
- **Arbitration, evaluated each cycle:**
  - If alu_valid && alu_ready && alu_rd!=0: issue the ALU result.
  - Else if count>0: issue the queue head and pop it.
  - Else: issue nothing.
- **Issue registers:** on issue, nD/D load the selected rd/data and RegWE<=1. Otherwise RegWE<=0 and nD/D hold their previous values.
- **Starvation counter:** 4-bit register `starve`.
  - Clears when count==0 or a pop occurs.
  - Otherwise increments, saturating at STARVE_MAX.
- **ALU throttle:** alu_ready = !Reset && (starve != STARVE_MAX). The ALU holds alu_valid/alu_rd/alu_data stable while alu_ready==0.
- **Push timing:** an entry pushed in cycle N is not eligible to issue until cycle N+1, because the queue read is registered state.
- **Order:** queue order is strictly FIFO. ALU results never reorder among themselves.

## Timing
- **Reset** (any cycle, including mid-operation):
  - next edge sets count=0, head=tail=0, starve=0, RegWE=0, nD=0, D=0;
  - all in-flight queue contents are discarded;
  - alu_ready and lsu_ready are 0 while Reset is high.
- **Latency:** ALU result accepted in cycle N → RegWE=1 with nD/D valid during cycle N+1 → register file captures it at the end of N+1.
- **Queued LSU latency:** minimum 2 cycles from acceptance to RegWE (push N, pop N+1, RegWE N+2).
- **Simultaneous events:**
  - Push and pop in the same cycle leave count unchanged.
  - If ALU issue and an LSU push coincide, both happen.
- **Full queue:** lsu_ready=0 the cycle count reaches LQ_DEPTH. It rises in the cycle after the pop that frees an entry.
- **Pointer wrap:** head and tail wrap modulo LQ_DEPTH.
- **Throughput:** at most one register-file write per cycle. Sustained peak is 1/cycle.

## Test plan
- **Reset values:** hold Reset 2 cycles with alu_valid=1, lsu_valid=1.
  - Required: RegWE=0, nD=0, D=0, lq_count=0, alu_ready=0, lsu_ready=0 throughout.
  - Required: first write appears ≥2 cycles after release.
- **ALU path and r0:** ALU rd=5, data=0x1234 in cycle N.
  - Required: RegWE=1, nD=5, D=0x1234 in N+1.
  - ALU rd=0, data=0xFFFF → RegWE=0 in the following cycle.
- **LSU FIFO order and backpressure:** LSU pushes rd=3/0xAAAA, then rd=4/0xBBBB while the ALU is idle.
  - Required: writes in that order at push+2.
  - With LQ_DEPTH=2 and the ALU continuously valid, the 3rd LSU beat sees lsu_ready=0 and lq_count=2.
- **Starvation:** ALU continuously valid to rd=1; one LSU entry rd=7/0x0707 pushed in cycle N.
  - Required: alu_ready=0 in cycle N+1+STARVE_MAX (N+4 for default STARVE_MAX=3).
  - Required: the LSU write appears the next cycle, then alu_ready returns to 1.
- **Mid-operation reset and wrap:** fill the queue with 2 entries, pulse Reset 1 cycle.
  - Required: lq_count=0 and no write of the old entries.
  - Required: 5 subsequent pushes/pops across wrap all emerge in order with correct data.
